decode_issue_queue: RTL and testbench



---
 rtl/decode_issue_queue_pkg.sv | 103 ++++++++++
 rtl/decode_issue_queue_inst_ctrl_decode.sv | 118 +++++++++++
 rtl/decode_issue_queue.sv | 120 ++++++++++++
 tb/tb_decode_issue_queue.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_issue_queue_pkg.sv
// decode_issue_queue_pkg
//   Shared constants for the decode/issue queue: MIPS-I opcode, funct and
//   COP0 rs encodings, plus the bit positions of the 24-bit control bundle.
//   A helper reports whether a bundle must freeze issue behind it.
package decode_issue_queue_pkg;

  localparam int CTRL_W = 24;

  // out_ctrl bit positions
  localparam int CTRL_JUMP       = 0;
  localparam int CTRL_MEMTOREG   = 1;
  localparam int CTRL_BRANCH     = 2;
  localparam int CTRL_ALUSRC     = 3;
  localparam int CTRL_REGDST     = 4;
  localparam int CTRL_REGWRITE   = 5;
  localparam int CTRL_IS_UIMM    = 6;
  localparam int CTRL_LO_EN      = 7;
  localparam int CTRL_HI_EN      = 8;
  localparam int CTRL_DMOV_WRITE = 9;
  localparam int CTRL_DMOV_READ  = 10;
  localparam int CTRL_MULDIV     = 11;
  localparam int CTRL_MEM_SIGNED = 12;
  localparam int CTRL_MEM_WORD   = 13;
  localparam int CTRL_MEM_HALF   = 14;
  localparam int CTRL_MEM_BYTE   = 15;
  localparam int CTRL_MEM_WE     = 16;
  localparam int CTRL_JR         = 17;
  localparam int CTRL_JALR       = 18;
  localparam int CTRL_BREAK      = 19;
  localparam int CTRL_SYSCALL    = 20;
  localparam int CTRL_ERET       = 21;
  localparam int CTRL_CP0_WE     = 22;
  localparam int CTRL_RI         = 23;

  // primary opcodes
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_COP0   = 6'h10;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_SLLV    = 6'h04;
  localparam logic [5:0] FN_SRLV    = 6'h06;
  localparam logic [5:0] FN_SRAV    = 6'h07;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_BREAK   = 6'h0D;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1A;
  localparam logic [5:0] FN_DIVU    = 6'h1B;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2A;
  localparam logic [5:0] FN_SLTU    = 6'h2B;

  // COP0 rs field
  localparam logic [4:0] RS_MFC0 = 5'b00000;
  localparam logic [4:0] RS_MTC0 = 5'b00100;

  // ERET is the single COP0 word 0x42000018; these are its low 26 bits.
  localparam logic [25:0] ERET_LOW = 26'h200_0018;

  function automatic logic is_serialising(input logic [CTRL_W-1:0] c);
    return c[CTRL_BREAK] | c[CTRL_SYSCALL] | c[CTRL_ERET] | c[CTRL_RI];
  endfunction

endpackage

// File: rtl/decode_issue_queue_inst_ctrl_decode.sv
// inst_ctrl_decode
//   Purely combinational MIPS-I control decoder.
//   instr : 32-bit instruction word
//   ctrl  : 24-bit control bundle (bit layout in decode_issue_queue_pkg)
//   Anything not recognised yields only the reserved-instruction bit.
module inst_ctrl_decode
  import decode_issue_queue_pkg::*;
(
  input  logic [31:0]       instr,
  output logic [CTRL_W-1:0] ctrl
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       legal;
  logic [CTRL_W-1:0] c;

  assign op = instr[31:26];
  assign rs = instr[25:21];
  assign rt = instr[20:16];
  assign fn = instr[5:0];

  always_comb begin
    c     = '0;
    legal = 1'b1;
    // Sign-extending loads are the norm; only LBU/LHU clear this below.
    c[CTRL_MEM_SIGNED] = 1'b1;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
          FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
            c[CTRL_REGWRITE] = 1'b1;
            c[CTRL_REGDST]   = 1'b1;
          end
          FN_JR: c[CTRL_JR] = 1'b1;
          FN_JALR: begin
            c[CTRL_JALR]     = 1'b1;
            c[CTRL_REGWRITE] = 1'b1;
            c[CTRL_REGDST]   = 1'b1;
          end
          FN_SYSCALL: c[CTRL_SYSCALL] = 1'b1;
          FN_BREAK:   c[CTRL_BREAK]   = 1'b1;
          FN_MFHI, FN_MFLO: begin
            c[CTRL_REGWRITE]  = 1'b1;
            c[CTRL_REGDST]    = 1'b1;
            c[CTRL_DMOV_READ] = 1'b1;
            c[CTRL_HI_EN]     = (fn == FN_MFHI);
            c[CTRL_LO_EN]     = (fn == FN_MFLO);
          end
          FN_MTHI, FN_MTLO: begin
            c[CTRL_DMOV_WRITE] = 1'b1;
            c[CTRL_HI_EN]      = (fn == FN_MTHI);
            c[CTRL_LO_EN]      = (fn == FN_MTLO);
          end
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            c[CTRL_MULDIV] = 1'b1;
            c[CTRL_HI_EN]  = 1'b1;
            c[CTRL_LO_EN]  = 1'b1;
          end
          default: legal = 1'b0;
        endcase
      end
      OP_REGIMM: begin
        // BLTZ/BGEZ/BLTZAL/BGEZAL: rt in {00000,00001,10000,10001}; rt[4] links.
        if (rt[3:1] == 3'b000) begin
          c[CTRL_BRANCH]   = 1'b1;
          c[CTRL_REGWRITE] = rt[4];
        end else begin
          legal = 1'b0;
        end
      end
      OP_J: c[CTRL_JUMP] = 1'b1;
      OP_JAL: begin
        c[CTRL_JUMP]     = 1'b1;
        c[CTRL_REGWRITE] = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: c[CTRL_BRANCH] = 1'b1;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        c[CTRL_REGWRITE] = 1'b1;
        c[CTRL_ALUSRC]   = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        c[CTRL_REGWRITE] = 1'b1;
        c[CTRL_ALUSRC]   = 1'b1;
        c[CTRL_IS_UIMM]  = 1'b1;
      end
      OP_COP0: begin
        if (rs == RS_MFC0)                c[CTRL_REGWRITE] = 1'b1;
        else if (rs == RS_MTC0)           c[CTRL_CP0_WE]   = 1'b1;
        else if (instr[25:0] == ERET_LOW) c[CTRL_ERET]     = 1'b1;
        else                              legal = 1'b0;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        c[CTRL_REGWRITE]   = 1'b1;
        c[CTRL_ALUSRC]     = 1'b1;
        c[CTRL_MEMTOREG]   = 1'b1;
        c[CTRL_MEM_BYTE]   = (op == OP_LB) | (op == OP_LBU);
        c[CTRL_MEM_HALF]   = (op == OP_LH) | (op == OP_LHU);
        c[CTRL_MEM_WORD]   = (op == OP_LW);
        c[CTRL_MEM_SIGNED] = ~((op == OP_LBU) | (op == OP_LHU));
      end
      OP_SB, OP_SH, OP_SW: begin
        c[CTRL_ALUSRC]   = 1'b1;
        c[CTRL_MEM_WE]   = 1'b1;
        c[CTRL_MEM_BYTE] = (op == OP_SB);
        c[CTRL_MEM_HALF] = (op == OP_SH);
        c[CTRL_MEM_WORD] = (op == OP_SW);
      end
      default: legal = 1'b0;
    endcase
    ctrl = legal ? c : (CTRL_W'(1) << CTRL_RI);
  end

endmodule

// File: rtl/decode_issue_queue.sv
// decode_issue_queue
//   DEPTH-entry FIFO of fetched {pc, instr} pairs feeding a registered
//   valid/ready output stage carrying the decoded control bundle.
//   Break/syscall/eret/reserved entries freeze further issue (halted)
//   until flush or rst.
//   Optional macro DIQ_BYPASS_EN: an accepted push into an empty FIFO with
//   a free output register is loaded directly (1-cycle latency).
//   Ports:
//     clk, rst         clock, synchronous active-high reset
//     flush            drop all buffered/registered entries, clear halted
//     in_valid/in_ready, in_pc, in_instr    fetch side
//     out_valid/out_ready, out_pc, out_instr, out_ctrl   issue side
//     count            FIFO occupancy (output register excluded)
//     halted           issue frozen behind a serialising instruction
module decode_issue_queue
  import decode_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [31:0]       in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [31:0]       out_instr,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  count,
  output logic              halted
);

  localparam int AW = $clog2(DEPTH);

  logic [PC_W-1:0]   fifo_pc    [DEPTH];
  logic [31:0]       fifo_instr [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  logic              full;
  logic              empty;
  logic              push;
  logic              load_ok;
  logic              pop;
  logic              bypass;
  logic              fifo_push;
  logic              load;
  logic [PC_W-1:0]   dec_pc;
  logic [31:0]       dec_instr;
  logic [CTRL_W-1:0] dec_ctrl;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = ~full & ~flush;
  assign push      = in_valid & in_ready;
  assign load_ok   = ~halted & (~out_valid | out_ready);
  assign pop       = ~empty & load_ok & ~flush;

`ifdef DIQ_BYPASS_EN
  assign bypass    = push & empty & load_ok;
`else
  assign bypass    = 1'b0;
`endif

  assign fifo_push = push & ~bypass;
  assign load      = pop | bypass;
  assign dec_pc    = bypass ? in_pc    : fifo_pc[rd_ptr];
  assign dec_instr = bypass ? in_instr : fifo_instr[rd_ptr];

  inst_ctrl_decode u_dec (
    .instr (dec_instr),
    .ctrl  (dec_ctrl)
  );

  // Storage is not reset; occupancy is tracked by the pointers/count only.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_pc[wr_ptr]    <= in_pc;
      fifo_instr[wr_ptr] <= in_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
      if (rst) begin
        out_pc    <= '0;
        out_instr <= '0;
        out_ctrl  <= '0;
      end
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)       rd_ptr <= rd_ptr + AW'(1);
      case ({fifo_push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (load) begin
        out_valid <= 1'b1;
        out_pc    <= dec_pc;
        out_instr <= dec_instr;
        out_ctrl  <= dec_ctrl;
        if (is_serialising(dec_ctrl)) halted <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_issue_queue.sv
module tb_decode_issue_queue;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, in_ready, out_valid, out_ready, halted;
  logic [PC_W-1:0]   in_pc, out_pc;
  logic [31:0]       in_instr, out_instr;
  logic [23:0]       out_ctrl;
  logic [CNT_W-1:0]  count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  decode_issue_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .out_ctrl(out_ctrl), .count(count), .halted(halted)
  );

`ifdef DIQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- reference model ----------------
  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } entry_t;
  entry_t      q[$];
  logic        m_ov, m_halt;
  logic [31:0] m_pc, m_instr;
  logic [23:0] m_ctrl;

  typedef enum {K_RSV, K_ALUR, K_JR, K_JALR, K_SYS, K_BRK, K_MFHI, K_MTHI, K_MFLO,
                K_MTLO, K_MULDIV, K_BR, K_BRL, K_J, K_JAL, K_ALUI, K_LOGI,
                K_MFC0, K_MTC0, K_ERET, K_LOAD, K_STORE} kind_t;

  function automatic kind_t classify(input logic [31:0] w);
    logic [5:0] op, fn;
    logic [4:0] rs, rt;
    op = w[31:26]; fn = w[5:0]; rs = w[25:21]; rt = w[20:16];
    if (op == 6'h00) begin
      if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                     [6'h20:6'h27], 6'h2A, 6'h2B}) return K_ALUR;
      if (fn == 6'h08) return K_JR;
      if (fn == 6'h09) return K_JALR;
      if (fn == 6'h0C) return K_SYS;
      if (fn == 6'h0D) return K_BRK;
      if (fn == 6'h10) return K_MFHI;
      if (fn == 6'h11) return K_MTHI;
      if (fn == 6'h12) return K_MFLO;
      if (fn == 6'h13) return K_MTLO;
      if (fn inside {[6'h18:6'h1B]}) return K_MULDIV;
      return K_RSV;
    end
    if (op == 6'h01) begin
      if (rt inside {5'd0, 5'd1}) return K_BR;
      if (rt inside {5'd16, 5'd17}) return K_BRL;
      return K_RSV;
    end
    if (op == 6'h02) return K_J;
    if (op == 6'h03) return K_JAL;
    if (op inside {[6'h04:6'h07]}) return K_BR;
    if (op inside {[6'h08:6'h0B]}) return K_ALUI;
    if (op inside {[6'h0C:6'h0F]}) return K_LOGI;
    if (op == 6'h10) begin
      if (w == 32'h4200_0018) return K_ERET;
      if (rs == 5'b00000) return K_MFC0;
      if (rs == 5'b00100) return K_MTC0;
      return K_RSV;
    end
    if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) return K_LOAD;
    if (op inside {6'h28, 6'h29, 6'h2B}) return K_STORE;
    return K_RSV;
  endfunction

  function automatic logic [23:0] ref_ctrl(input logic [31:0] w);
    logic rw, rd, as, br, mr, jp, ui, hi, lo, dw, dr, md, ms, we, by, hf, wd;
    logic jr, jalr, brk, sys, er, cw;
    kind_t k;
    k = classify(w);
    {rw, rd, as, br, mr, jp, ui, hi, lo, dw, dr, md, we, by, hf, wd} = '0;
    {jr, jalr, brk, sys, er, cw} = '0;
    ms = 1'b1;
    if (k == K_RSV) return 24'h80_0000;
    case (k)
      K_ALUR:   begin rw = 1; rd = 1; end
      K_JR:     jr = 1;
      K_JALR:   begin jalr = 1; rw = 1; rd = 1; end
      K_SYS:    sys = 1;
      K_BRK:    brk = 1;
      K_MFHI:   begin rw = 1; rd = 1; dr = 1; hi = 1; end
      K_MFLO:   begin rw = 1; rd = 1; dr = 1; lo = 1; end
      K_MTHI:   begin dw = 1; hi = 1; end
      K_MTLO:   begin dw = 1; lo = 1; end
      K_MULDIV: begin md = 1; hi = 1; lo = 1; end
      K_BR:     br = 1;
      K_BRL:    begin br = 1; rw = 1; end
      K_J:      jp = 1;
      K_JAL:    begin jp = 1; rw = 1; end
      K_ALUI:   begin rw = 1; as = 1; end
      K_LOGI:   begin rw = 1; as = 1; ui = 1; end
      K_MFC0:   rw = 1;
      K_MTC0:   cw = 1;
      K_ERET:   er = 1;
      K_LOAD, K_STORE: begin
        as = 1;
        if (k == K_LOAD) begin rw = 1; mr = 1; end else we = 1;
        // op[1:0]: 00 byte, 01 half, 11 word
        by = (w[27:26] == 2'b00);
        hf = (w[27:26] == 2'b01);
        wd = (w[27:26] == 2'b11);
        if (k == K_LOAD && w[28]) ms = 0;   // LBU/LHU
      end
      default: ;
    endcase
    return {1'b0, cw, er, sys, brk, jalr, jr, we, by, hf, wd, ms, md, dr, dw,
            hi, lo, ui, rw, rd, as, br, mr, jp};
  endfunction

  function automatic logic serial(input logic [31:0] w);
    kind_t k;
    k = classify(w);
    return (k inside {K_RSV, K_SYS, K_BRK, K_ERET});
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance, update model, compare.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                      input logic ordy, input logic fl, input logic rs);
    logic push, can, byp, loaded;
    entry_t e;
    in_valid = v; in_pc = pc; in_instr = ins; out_ready = ordy; flush = fl; rst = rs;
    #1;
    if (!rs) check("in_ready_pre", 64'(in_ready), 64'((q.size() < DEPTH) && !fl));
    @(posedge clk);
    #1;
    if (rs || fl) begin
      q.delete(); m_ov = 0; m_halt = 0;
      if (rs) begin m_pc = 0; m_instr = 0; m_ctrl = 0; end
    end else begin
      push   = v && (q.size() < DEPTH);
      can    = !m_halt && (!m_ov || ordy);
      byp    = BYP && push && (q.size() == 0) && can;
      loaded = 0;
      e      = '0;
      if (can && q.size() != 0) begin e = q.pop_front(); loaded = 1; end
      else if (byp) begin e.pc = pc; e.instr = ins; loaded = 1; end
      if (push && !byp) q.push_back('{pc: pc, instr: ins});
      if (loaded) begin
        m_ov = 1; m_pc = e.pc; m_instr = e.instr; m_ctrl = ref_ctrl(e.instr);
        if (serial(e.instr)) m_halt = 1;
      end else if (m_ov && ordy) begin
        m_ov = 0;
      end
    end
    check("out_valid", 64'(out_valid), 64'(m_ov));
    check("count", 64'(count), 64'(q.size()));
    check("halted", 64'(halted), 64'(m_halt));
    if (m_ov || rs) begin
      check("out_pc", 64'(out_pc), 64'(m_pc));
      check("out_instr", 64'(out_instr), 64'(m_instr));
      check("out_ctrl", 64'(out_ctrl), 64'(m_ctrl));
    end
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'h0, 32'h0, ordy, 1'b0, 1'b0);
  endtask

  // Push into an empty queue with out_ready low and wait the expected
  // latency, leaving the entry held in the output register.
  task automatic push_show(input logic [31:0] pc, input logic [31:0] ins);
    step(1'b1, pc, ins, 1'b0, 1'b0, 1'b0);
    if (!BYP) begin
      check("lat_not_yet", 64'(out_valid), 64'(0));
      idle(1'b0);
    end
    check("lat_valid", 64'(out_valid), 64'(1));
    check("lat_pc", 64'(out_pc), 64'(pc));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [5:0] rf[24] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
                           6'h0C, 6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A,
                           6'h1B, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A};
    logic [5:0] io[18] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09,
                           6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h20, 6'h21, 6'h23, 6'h24,
                           6'h25, 6'h2B};
    logic [4:0] rti[4] = '{5'd0, 5'd1, 5'd16, 5'd17};
    int sel;
    w = $urandom;
    sel = $urandom_range(0, 19);
    if (sel < 9)       begin w[31:26] = 6'h00; w[5:0] = rf[$urandom_range(0, 23)]; end
    else if (sel < 17) w[31:26] = io[$urandom_range(0, 17)];
    else if (sel < 19) begin w[31:26] = 6'h01; w[20:16] = rti[$urandom_range(0, 3)]; end
    return w;
  endfunction

  initial begin
    logic [31:0] pc;
    m_ov = 0; m_halt = 0; m_pc = 0; m_instr = 0; m_ctrl = 0;
    in_valid = 0; in_pc = 0; in_instr = 0; out_ready = 0; flush = 0; rst = 1;

    // reset
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    check("rst_ctrl", 64'(out_ctrl), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    idle(1'b1);

    // ADDU
    push_show(32'hBFC0_0000, 32'h0085_1021);
    check("addu_ctrl50", 64'(out_ctrl[5:0]), 64'(6'b110000));
    check("addu_ri", 64'(out_ctrl[23]), 64'(0));
    idle(1'b1);
    // LBU
    push_show(32'hBFC0_0004, 32'h90A2_0004);
    check("lbu_ctrl50", 64'(out_ctrl[5:0]), 64'(6'b101010));
    check("lbu_mem", 64'(out_ctrl[16:13]), 64'(4'b0100));
    check("lbu_signed", 64'(out_ctrl[12]), 64'(0));
    idle(1'b1);
    // SW
    push_show(32'hBFC0_0008, 32'hACA2_0000);
    check("sw_mem", 64'(out_ctrl[16:13]), 64'(4'b1001));
    check("sw_ctrl50", 64'(out_ctrl[5:0]), 64'(6'b001000));
    idle(1'b1);

    // back-pressure: 6 back-to-back pushes, capacity DEPTH+1
    for (int i = 0; i < 6; i++) begin
      if (i == 5) check("full_in_ready", 64'(in_ready), 64'(0));
      step(1'b1, 32'h100 + 32'(4 * i), 32'h0085_1021, 1'b0, 1'b0, 1'b0);
    end
    check("full_count", 64'(count), 64'(DEPTH));
    for (int i = 0; i < 7; i++) idle(1'b1);
    check("drained", 64'(out_valid), 64'(0));

    // SYSCALL then ADDU: ADDU held behind halted
    push_show(32'h200, 32'h0000_000C);
    check("sys_bit", 64'(out_ctrl[20]), 64'(1));
    check("sys_halted", 64'(halted), 64'(1));
    step(1'b1, 32'h204, 32'h0085_1021, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    check("held_count", 64'(count), 64'(1));
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    check("flush_count", 64'(count), 64'(0));
    check("flush_halted", 64'(halted), 64'(0));
    check("flush_valid", 64'(out_valid), 64'(0));

    // reserved, then MULT after flush
    push_show(32'h300, 32'hFC00_0000);
    check("rsv_ctrl", 64'(out_ctrl), 64'(24'h80_0000));
    check("rsv_halted", 64'(halted), 64'(1));
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    push_show(32'h304, 32'h0085_0018);
    check("mult_hilo", 64'(out_ctrl[8:7]), 64'(2'b11));
    check("mult_md", 64'(out_ctrl[11]), 64'(1));
    check("mult_rw", 64'(out_ctrl[5]), 64'(0));
    idle(1'b1);

    // flush with concurrent in_valid drops the entry
    step(1'b1, 32'h400, 32'h0085_1021, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    check("flushdrop_count", 64'(count), 64'(0));
    check("flushdrop_valid", 64'(out_valid), 64'(0));

    // pointer wrap: 3*DEPTH streaming push/pop pairs
    for (int i = 0; i < 3 * DEPTH; i++)
      step(1'b1, 32'h500 + 32'(4 * i), 32'h0085_1021 + 32'(i << 11), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // mid-run reset
    step(1'b1, 32'h600, 32'h0085_1021, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h604, 32'h0085_1021, 1'b0, 1'b0, 1'b1);

    // randomized traffic
    pc = 32'h1000;
    for (int i = 0; i < 3000; i++) begin
      logic v, r, f;
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      f = ($urandom_range(0, 24) == 0);
      step(v, pc, rand_instr(), r, f, 1'b0);
      pc = pc + 4;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
